// File: rtl/dds_serial_writer.sv
// Serial register writer for a DDS: snapshots the register image on CEN, streams
// seven instruction+payload writes MSB first, then pulses DDS_UDCLK and reports READY.
module dds_serial_writer #(
  parameter int unsigned DIV = 4,
  parameter int unsigned UDW = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CEN,
  input  logic [15:0] F1H,
  input  logic [31:0] F1L,
  input  logic [15:0] F2H,
  input  logic [31:0] F2L,
  input  logic [15:0] DFWH,
  input  logic [31:0] DFWL,
  input  logic [13:0] PTW1,
  input  logic [13:0] PTW2,
  input  logic [19:0] RAMPRATE,
  input  logic [2:0]  MODE,
  input  logic        TRAIANGLE,
  input  logic        PLLEN,
  input  logic [4:0]  CLKMUILT,
  input  logic        PLLRANGE,
  input  logic        OSK,
  output logic        READY,
  output logic        BUSY,
  output logic        DDS_CSN,
  output logic        DDS_SCLK,
  output logic        DDS_SDIO,
  output logic        DDS_UDCLK
);

  localparam int unsigned FRAME_W = 56;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned XFER_W  = 3;
  localparam int unsigned CNT_MAX = (DIV > UDW) ? DIV : UDW;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [XFER_W-1:0] LAST_XFER = XFER_W'(6);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                half, half_d;
  logic [BIT_W-1:0]    bit_cnt, bit_d;
  logic [XFER_W-1:0]   xfer, xfer_d, xfer_nx;
  logic [FRAME_W-1:0]  sreg, sreg_d, frame_nx;
  logic [BIT_W-1:0]    last_bit;

  logic [13:0]         ptw1_q, ptw2_q;
  logic [47:0]         f1_q, f2_q, dfw_q;
  logic [19:0]         ramp_q;
  logic [31:0]         cw_q, cw_c;

  logic                csn_d, sclk_d, sdio_d, udclk_d, ready_d, busy_d;

  logic                div_end, ud_end, start;

  assign div_end = (cnt == CNT_W'(DIV - 1));
  assign ud_end  = (cnt == CNT_W'(UDW - 1));
  assign start   = (state == S_IDLE) && CEN;
  assign xfer_nx = xfer + XFER_W'(1);

  // Control word with external update selected; unlisted bits stay zero.
  always_comb begin
    cw_c        = '0;
    cw_c[22]    = PLLRANGE;
    cw_c[21]    = ~PLLEN;
    cw_c[20:16] = CLKMUILT;
    cw_c[13]    = TRAIANGLE;
    cw_c[11:9]  = MODE;
    cw_c[8]     = 1'b0;
    cw_c[5]     = OSK;
  end

  // Index of the final bit of the current transfer (instruction + payload).
  always_comb begin
    last_bit = BIT_W'(23);
    case (xfer)
      3'd0, 3'd1:       last_bit = BIT_W'(23);
      3'd2, 3'd3, 3'd4: last_bit = BIT_W'(55);
      3'd5:             last_bit = BIT_W'(31);
      3'd6:             last_bit = BIT_W'(39);
      default:          last_bit = BIT_W'(23);
    endcase
  end

  // Left-aligned frame for the following transfer, built from the snapshot.
  always_comb begin
    frame_nx = '0;
    case (xfer_nx)
      3'd1:    frame_nx = {8'h01, 2'b00, ptw2_q, 32'h0};
      3'd2:    frame_nx = {8'h02, f1_q};
      3'd3:    frame_nx = {8'h03, f2_q};
      3'd4:    frame_nx = {8'h04, dfw_q};
      3'd5:    frame_nx = {8'h06, 4'h0, ramp_q, 24'h0};
      3'd6:    frame_nx = {8'h07, cw_q, 16'h0};
      default: frame_nx = '0;
    endcase
  end

  // State register together with the sequencing counters and shift register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      half    <= 1'b0;
      bit_cnt <= '0;
      xfer    <= '0;
      sreg    <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      half    <= half_d;
      bit_cnt <= bit_d;
      xfer    <= xfer_d;
      sreg    <= sreg_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    half_d  = half;
    bit_d   = bit_cnt;
    xfer_d  = xfer;
    sreg_d  = sreg;
    case (state)
      S_IDLE: begin
        if (CEN) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          xfer_d  = '0;
          sreg_d  = {8'h00, 2'b00, PTW1, 32'h0};
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          cnt_d = '0;
          if (!half) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_cnt == last_bit) begin
              state_d = S_GAP;
            end else begin
              bit_d  = bit_cnt + BIT_W'(1);
              sreg_d = {sreg[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (div_end) begin
          cnt_d = '0;
          if (xfer == LAST_XFER) begin
            state_d = S_UPDATE;
          end else begin
            state_d = S_SHIFT;
            xfer_d  = xfer_nx;
            bit_d   = '0;
            half_d  = 1'b0;
            sreg_d  = frame_nx;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_UPDATE: begin
        if (ud_end) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    csn_d   = 1'b1;
    sclk_d  = 1'b0;
    sdio_d  = sreg_d[FRAME_W-1];
    udclk_d = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      S_SHIFT: begin
        csn_d  = 1'b0;
        sclk_d = half_d;
        busy_d = 1'b1;
      end
      S_GAP:    busy_d = 1'b1;
      S_UPDATE: begin
        udclk_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE:   ready_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DDS_CSN   <= 1'b1;
      DDS_SCLK  <= 1'b0;
      DDS_SDIO  <= 1'b0;
      DDS_UDCLK <= 1'b0;
      READY     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      DDS_CSN   <= csn_d;
      DDS_SCLK  <= sclk_d;
      DDS_SDIO  <= sdio_d;
      DDS_UDCLK <= udclk_d;
      READY     <= ready_d;
      BUSY      <= busy_d;
    end
  end

  // Register image captured once per sequence; later input changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptw1_q <= '0;
      ptw2_q <= '0;
      f1_q   <= '0;
      f2_q   <= '0;
      dfw_q  <= '0;
      ramp_q <= '0;
      cw_q   <= '0;
    end else if (start) begin
      ptw1_q <= PTW1;
      ptw2_q <= PTW2;
      f1_q   <= {F1H, F1L};
      f2_q   <= {F2H, F2L};
      dfw_q  <= {DFWH, DFWL};
      ramp_q <= RAMPRATE;
      cw_q   <= cw_c;
    end
  end

endmodule

// File: tb/tb_dds_serial_writer.sv
// Scoreboard bench for dds_serial_writer: expected serial frames are queued at
// stimulus time and compared by a monitor at every chip-select window close.
module tb_dds_serial_writer;

  typedef struct {
    int          nbits;
    logic [55:0] data;
    string       name;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        cen2 = 1'b0;
  logic [15:0] f1h, f2h, dfwh;
  logic [31:0] f1l, f2l, dfwl;
  logic [13:0] ptw1, ptw2;
  logic [19:0] ramprate;
  logic [2:0]  mode;
  logic        traiangle, pllen, pllrange, osk;
  logic [4:0]  clkmuilt;

  logic ready, busy, csn, sclk, sdio, udclk;
  logic ready2, busy2, csn2, sclk2, sdio2, udclk2;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     frames_seen = 0;
  bit     abort = 1'b0;
  frame_t q[$];

  dds_serial_writer dut (
    .CLK(clk), .RST(rst), .CEN(cen),
    .F1H(f1h), .F1L(f1l), .F2H(f2h), .F2L(f2l), .DFWH(dfwh), .DFWL(dfwl),
    .PTW1(ptw1), .PTW2(ptw2), .RAMPRATE(ramprate), .MODE(mode),
    .TRAIANGLE(traiangle), .PLLEN(pllen), .CLKMUILT(clkmuilt),
    .PLLRANGE(pllrange), .OSK(osk),
    .READY(ready), .BUSY(busy), .DDS_CSN(csn), .DDS_SCLK(sclk),
    .DDS_SDIO(sdio), .DDS_UDCLK(udclk)
  );

  dds_serial_writer #(.DIV(2), .UDW(1)) dut2 (
    .CLK(clk), .RST(rst), .CEN(cen2),
    .F1H(f1h), .F1L(f1l), .F2H(f2h), .F2L(f2l), .DFWH(dfwh), .DFWL(dfwl),
    .PTW1(ptw1), .PTW2(ptw2), .RAMPRATE(ramprate), .MODE(mode),
    .TRAIANGLE(traiangle), .PLLEN(pllen), .CLKMUILT(clkmuilt),
    .PLLRANGE(pllrange), .OSK(osk),
    .READY(ready2), .BUSY(busy2), .DDS_CSN(csn2), .DDS_SCLK(sclk2),
    .DDS_SDIO(sdio2), .DDS_UDCLK(udclk2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int n, input logic [55:0] d, input string nm);
    frame_t e;
    e.nbits = n;
    e.data  = d;
    e.name  = nm;
    q.push_back(e);
  endtask

  task automatic set_inputs(input int which);
    if (which == 1) begin
      ptw1 = 14'h1234; ptw2 = 14'h0ABC;
      f1h = 16'hABCD; f1l = 32'h01234567;
      f2h = 16'h1357; f2l = 32'h9BDF0246;
      dfwh = 16'h0011; dfwl = 32'h22334455;
      ramprate = 20'hABCDE; mode = 3'b011; traiangle = 1'b0;
      pllen = 1'b0; clkmuilt = 5'h14; pllrange = 1'b1; osk = 1'b1;
    end else begin
      ptw1 = 14'h3FFF; ptw2 = 14'h0000;
      f1h = 16'hFFFF; f1l = 32'h00000000;
      f2h = 16'h8000; f2l = 32'h00000001;
      dfwh = 16'hFEDC; dfwl = 32'hBA987654;
      ramprate = 20'hFFFFF; mode = 3'b101; traiangle = 1'b1;
      pllen = 1'b1; clkmuilt = 5'h1F; pllrange = 1'b0; osk = 1'b0;
    end
  endtask

  // Hand-computed frames for each input set (instruction byte then payload).
  task automatic push_frames(input int which, input string tag);
    if (which == 1) begin
      push(24, 56'h001234,         {tag, "_ptw1"});
      push(24, 56'h010ABC,         {tag, "_ptw2"});
      push(56, 56'h02ABCD01234567, {tag, "_ftw1"});
      push(56, 56'h0313579BDF0246, {tag, "_ftw2"});
      push(56, 56'h04001122334455, {tag, "_dfw"});
      push(32, 56'h060ABCDE,       {tag, "_ramp"});
      push(40, 56'h0700740620,     {tag, "_cw"});
    end else begin
      push(24, 56'h003FFF,         {tag, "_ptw1"});
      push(24, 56'h010000,         {tag, "_ptw2"});
      push(56, 56'h02FFFF00000000, {tag, "_ftw1"});
      push(56, 56'h03800000000001, {tag, "_ftw2"});
      push(56, 56'h04FEDCBA987654, {tag, "_dfw"});
      push(32, 56'h060FFFFF,       {tag, "_ramp"});
      push(40, 56'h07001F2A00,     {tag, "_cw"});
    end
  endtask

  // Monitor: collect bits on SCLK rise, score each window when CSN rises.
  initial begin : monitor
    int          nb;
    logic [55:0] acc;
    logic        p_sclk, p_csn, p_sdio;
    frame_t      e;
    nb = 0; acc = '0; p_sclk = 1'b0; p_csn = 1'b1; p_sdio = 1'b0;
    forever begin
      @(negedge clk);
      if (p_csn && !csn) begin
        nb = 0;
        acc = '0;
      end
      if (!csn && !p_sclk && sclk) begin
        acc = {acc[54:0], sdio};
        nb++;
      end
      if (!p_csn && csn && !abort) begin
        if (q.size() == 0) begin
          check("extra_frame_bits", 64'(nb), 64'd0);
        end else begin
          e = q.pop_front();
          check({e.name, "_bits"}, 64'(nb), 64'(e.nbits));
          check({e.name, "_data"}, 64'(acc), 64'(e.data));
          frames_seen++;
        end
      end
      if (!rst && !abort && (sdio !== p_sdio) && !(p_sclk && !sclk) && !(p_csn && !csn))
        check("sdio_change_off_sclk_fall", 64'(sdio), 64'(p_sdio));
      p_sclk = sclk;
      p_csn  = csn;
      p_sdio = sdio;
    end
  end

  task automatic start1(output int k);
    @(negedge clk);
    cen = 1'b1;
    @(posedge clk);
    #1 cen = 1'b0;
    k = cyc;
  endtask

  // One full sequence with timing checks; poke re-pulses CEN and changes inputs mid-run.
  task automatic run_seq(input bit poke, input string tag);
    int k, rdy_at, busy_n, ud_n, base;
    bit got;
    base = frames_seen;
    busy_n = 0; ud_n = 0; rdy_at = 0; got = 1'b0;
    start1(k);
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (udclk) ud_n++;
      if (ready) begin
        got = 1'b1;
        rdy_at = cyc;
        if (poke) cen = 1'b1;
      end
      if (poke && i == 100) begin
        set_inputs(2);
        cen = 1'b1;
      end
      if (poke && i == 101) cen = 1'b0;
    end
    check({tag, "_ready_seen"}, 64'(got), 64'd1);
    check({tag, "_ready_latency"}, 64'(rdy_at - k), 64'd2340);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd2340);
    check({tag, "_udclk_width"}, 64'(ud_n), 64'd8);
    check({tag, "_busy_at_ready"}, 64'(busy), 64'd0);
    @(negedge clk);
    cen = 1'b0;
    check({tag, "_ready_single"}, 64'(ready), 64'd0);
    repeat (30) @(negedge clk);
    check({tag, "_no_restart_busy"}, 64'(busy), 64'd0);
    check({tag, "_no_restart_csn"}, 64'(csn), 64'd1);
    check({tag, "_frames"}, 64'(frames_seen - base), 64'd7);
  endtask

  initial begin : stim
    int base, k, rdy, r1, r2, nrise, win_done;
    logic [23:0] acc2;
    logic p_sclk2, p_csn2;
    bit got;
    set_inputs(1);
    repeat (3) @(negedge clk);
    check("rst_csn", 64'(csn), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_sdio", 64'(sdio), 64'd0);
    check("idle_udclk", 64'(udclk), 64'd0);
    check("idle_ready", 64'(ready), 64'd0);

    push_frames(1, "seq1");
    run_seq(1'b1, "seq1");

    // Reset in the middle of the FTW2 transfer.
    base = frames_seen;
    push_frames(2, "seq2");
    start1(k);
    for (int i = 0; i < 3000 && frames_seen < base + 3; i++) @(negedge clk);
    check("seq2_reached_ftw2", 64'(frames_seen - base), 64'd3);
    repeat (60) @(negedge clk);
    check("seq2_mid_csn", 64'(csn), 64'd0);
    #2 abort = 1'b1;
    rst = 1'b1;
    #1;
    check("abort_csn", 64'(csn), 64'd1);
    check("abort_sclk", 64'(sclk), 64'd0);
    check("abort_sdio", 64'(sdio), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_udclk", 64'(udclk), 64'd0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_csn", 64'(csn), 64'd1);
    check("post_rst_frames", 64'(frames_seen - base), 64'd3);
    abort = 1'b0;

    push_frames(2, "seq3");
    run_seq(1'b0, "seq3");

    // Fast instance: DIV=2, UDW=1.
    got = 1'b0; rdy = 0; r1 = 0; r2 = 0; nrise = 0; win_done = 0; acc2 = '0;
    p_sclk2 = 1'b0; p_csn2 = 1'b1;
    @(negedge clk);
    cen2 = 1'b1;
    @(posedge clk);
    #1 cen2 = 1'b0;
    k = cyc;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (!csn2 && !p_sclk2 && sclk2 && win_done == 0) begin
        nrise++;
        acc2 = {acc2[22:0], sdio2};
        if (nrise == 1) r1 = cyc;
        if (nrise == 2) r2 = cyc;
      end
      if (!p_csn2 && csn2) win_done++;
      if (ready2) begin
        got = 1'b1;
        rdy = cyc;
      end
      p_sclk2 = sclk2;
      p_csn2 = csn2;
    end
    check("div2_ready_latency", 64'(rdy - k), 64'd1167);
    check("div2_sclk_period", 64'(r2 - r1), 64'd4);
    check("div2_first_bits", 64'(nrise), 64'd24);
    check("div2_first_data", 64'(acc2), 64'h003FFF);
    repeat (5) @(negedge clk);
    check("final_queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion (%0d miscompares so far)", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
